// File: rtl/gon_gather_ctrl.sv
// Gather controller: queues (row, col) requests, matches them against scan-loaded
// PE IDs and returns the lowest-index enabled PE's data, or an error on miss/timeout.

module gon_gather_lane #(
  parameter int ID_LEN  = 5,
  parameter int ROW_LEN = 4
) (
  input  logic [ROW_LEN-1:0] row_id_i,
  input  logic [ID_LEN-1:0]  col_id_i,
  input  logic [ROW_LEN-1:0] cur_row_i,
  input  logic [ID_LEN-1:0]  cur_col_i,
  output logic               match_o
);
  assign match_o = (row_id_i == cur_row_i) && (col_id_i == cur_col_i);
endmodule

module gon_gather_ctrl #(
  parameter int XBUS_NUMS = 12,
  parameter int PE_NUMS   = 14,
  parameter int ID_LEN    = 5,
  parameter int ROW_LEN   = 4,
  parameter int VALUE_LEN = 32,
  parameter int REQ_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [ROW_LEN-1:0]                     req_row,
  input  logic [ID_LEN-1:0]                      req_col,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [VALUE_LEN-1:0]                   out_data,
  output logic [ROW_LEN-1:0]                     out_row,
  output logic [ID_LEN-1:0]                      out_col,
  output logic                                   out_err,
  output logic                                   busy,
  input  logic                                   set_row,
  input  logic [ROW_LEN-1:0]                     row_scan_in,
  output logic [ROW_LEN-1:0]                     row_scan_out,
  input  logic                                   set_id,
  input  logic [ID_LEN-1:0]                      id_scan_in,
  output logic [ID_LEN-1:0]                      id_scan_out,
  output logic [XBUS_NUMS*PE_NUMS-1:0]           pe_ready,
  input  logic [XBUS_NUMS*PE_NUMS-1:0]           pe_enable,
  input  logic [XBUS_NUMS*PE_NUMS*VALUE_LEN-1:0] pe_data
);
  localparam int N  = XBUS_NUMS * PE_NUMS;
  localparam int AW = $clog2(REQ_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(REQ_DEPTH);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  typedef struct packed {
    logic [ROW_LEN-1:0] row;
    logic [ID_LEN-1:0]  col;
  } req_t;

  state_e state_q, state_d;
  req_t   cur_q, cur_d;
  req_t   fifo_q [REQ_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [VALUE_LEN-1:0] data_q, data_d, sel_data;
  logic err_q, err_d;
  logic push, pop, full, empty, hit;

  logic [XBUS_NUMS-1:0][ROW_LEN-1:0] row_id_q, row_id_d;
  logic [N-1:0][ID_LEN-1:0]          col_id_q, col_id_d;
  logic [N-1:0]                      match;

  // ID scan chains: index 0 takes the scan input, the last index is the scan output.
  always_comb begin
    row_id_d = row_id_q;
    col_id_d = col_id_q;
    if (set_row) begin
      row_id_d[0] = row_scan_in;
      for (int i = 1; i < XBUS_NUMS; i++) row_id_d[i] = row_id_q[i-1];
    end
    if (set_id) begin
      col_id_d[0] = id_scan_in;
      for (int i = 1; i < N; i++) col_id_d[i] = col_id_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_id_q <= '0;
      col_id_q <= '0;
    end else begin
      row_id_q <= row_id_d;
      col_id_q <= col_id_d;
    end
  end

  assign row_scan_out = row_id_q[XBUS_NUMS-1];
  assign id_scan_out  = col_id_q[N-1];

  for (genvar k = 0; k < N; k++) begin : g_lane
    gon_gather_lane #(.ID_LEN(ID_LEN), .ROW_LEN(ROW_LEN)) u_lane (
      .row_id_i  (row_id_q[k/PE_NUMS]),
      .col_id_i  (col_id_q[k]),
      .cur_row_i (cur_q.row),
      .cur_col_i (cur_q.col),
      .match_o   (match[k])
    );
  end

  // Descending scan so the lowest-index enabled match wins.
  always_comb begin
    hit      = 1'b0;
    sel_data = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (match[k] && pe_enable[k]) begin
        hit      = 1'b1;
        sel_data = pe_data[k*VALUE_LEN +: VALUE_LEN];
      end
    end
  end

  assign full      = (cnt_q == DEPTH_C);
  assign empty     = (cnt_q == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage needs no reset; occupancy tracking gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= {req_row, req_col};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    cur_d   = cur_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        // Hold off while IDs are being reloaded.
        if (!empty && !set_row && !set_id) begin
          pop     = 1'b1;
          cur_d   = fifo_q[rptr_q];
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (hit) begin
          data_d  = sel_data;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (!(|match) || (tmo_q == TMO_LAST)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = data_q;
  assign out_row   = cur_q.row;
  assign out_col   = cur_q.col;
  assign out_err   = err_q;
  assign pe_ready  = (state_q == S_WAIT) ? match : '0;

endmodule

// File: tb/tb_gon_gather_ctrl.sv
// Directed bench for gon_gather_ctrl: vector table for request outcomes plus
// hand sequences for latency, FIFO back-pressure, duplicate matches and reset.

module tb_gon_gather_ctrl;
  localparam int XB = 12, PN = 14, IL = 5, RL = 4, VL = 32, DEP = 4, TMO = 8;
  localparam int N = XB * PN;

  logic clk, rst;
  logic req_valid, req_ready, out_valid, out_ready, out_err, busy;
  logic [RL-1:0] req_row, out_row, row_scan_in, row_scan_out;
  logic [IL-1:0] req_col, out_col, id_scan_in, id_scan_out;
  logic [VL-1:0] out_data;
  logic set_row, set_id;
  logic [N-1:0] pe_ready, pe_enable;
  logic [N*VL-1:0] pe_data;

  int total = 0, bad = 0;

  gon_gather_ctrl #(
    .XBUS_NUMS(XB), .PE_NUMS(PN), .ID_LEN(IL), .ROW_LEN(RL),
    .VALUE_LEN(VL), .REQ_DEPTH(DEP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row), .req_col(req_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_err(out_err), .busy(busy),
    .set_row(set_row), .row_scan_in(row_scan_in), .row_scan_out(row_scan_out),
    .set_id(set_id), .id_scan_in(id_scan_in), .id_scan_out(id_scan_out),
    .pe_ready(pe_ready), .pe_enable(pe_enable), .pe_data(pe_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          row, col;
    int          ea;  logic [31:0] da;
    int          eb;  logic [31:0] db;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_wait, exp_prdy;
  } vec_t;

  vec_t tbl [6];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic scan_rows(input bit alias2);
    set_row = 1'b1;
    for (int i = XB-1; i >= 0; i--) begin
      row_scan_in = RL'((alias2 && i == 2) ? 1 : i);
      tick();
    end
    set_row = 1'b0;
  endtask

  task automatic scan_cols();
    set_id = 1'b1;
    for (int k = N-1; k >= 0; k--) begin
      id_scan_in = IL'(k % PN);
      tick();
    end
    set_id = 1'b0;
  endtask

  task automatic run_req(input string nm, input vec_t v);
    int w, p;
    pe_enable = '0;
    pe_data   = '0;
    if (v.ea >= 0) begin pe_enable[v.ea] = 1'b1; pe_data[v.ea*VL +: VL] = v.da; end
    if (v.eb >= 0) begin pe_enable[v.eb] = 1'b1; pe_data[v.eb*VL +: VL] = v.db; end
    req_valid = 1'b1; req_row = RL'(v.row); req_col = IL'(v.col);
    tick();
    req_valid = 1'b0;
    w = 0; p = 0;
    for (int c = 0; c < 400 && !out_valid; c++) begin
      if (busy) w++;
      if (|pe_ready) p++;
      tick();
    end
    chk({nm, " out_valid"}, 32'(out_valid), 1);
    chk({nm, " out_data"}, out_data, v.exp_data);
    chk({nm, " out_err"}, 32'(out_err), 32'(v.exp_err));
    chk({nm, " out_row"}, 32'(out_row), 32'(v.row));
    chk({nm, " out_col"}, 32'(out_col), 32'(v.col));
    chk({nm, " wait_cycles"}, 32'(w), 32'(v.exp_wait));
    chk({nm, " pe_ready_cycles"}, 32'(p), 32'(v.exp_prdy));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, " back_idle"}, 32'(busy), 0);
    pe_enable = '0;
  endtask

  initial begin : main
    logic [N-1:0] m;
    int got, extra;

    // PE k: row k/14, col k%14 after the standard scan.
    tbl[0] = '{3, 5, 47, 32'hDEADBEEF, -1, 0, 32'hDEADBEEF, 1'b0, 1, 1};
    tbl[1] = '{15, 31, -1, 0, -1, 0, 32'h0, 1'b1, 1, 0};
    tbl[2] = '{0, 0, 0, 32'h0000A5A5, -1, 0, 32'h0000A5A5, 1'b0, 1, 1};
    tbl[3] = '{11, 13, 167, 32'hCAFEF00D, -1, 0, 32'hCAFEF00D, 1'b0, 1, 1};
    tbl[4] = '{5, 2, 72, 32'h12345678, 73, 32'h55, 32'h12345678, 1'b0, 1, 1};
    tbl[5] = '{3, 5, 46, 32'h77, -1, 0, 32'h0, 1'b1, TMO, TMO};

    rst = 1'b0; req_valid = 1'b0; req_row = '0; req_col = '0; out_ready = 1'b0;
    set_row = 1'b0; set_id = 1'b0; row_scan_in = '0; id_scan_in = '0;
    pe_enable = '0; pe_data = '0;
    #12;
    chk("rst req_ready", 32'(req_ready), 1);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst pe_ready", 32'(|pe_ready), 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_err", 32'(out_err), 0);
    chk("rst row_scan_out", 32'(row_scan_out), 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    scan_rows(1'b0);
    scan_cols();
    chk("scan row_scan_out", 32'(row_scan_out), 11);
    chk("scan id_scan_out", 32'(id_scan_out), 13);

    // Latency: push at edge t, pop at t+1, capture at t+2.
    pe_enable = '0; pe_enable[47] = 1'b1; pe_data[47*VL +: VL] = 32'hDEADBEEF;
    req_valid = 1'b1; req_row = 4'd3; req_col = 5'd5;
    tick();
    req_valid = 1'b0;
    chk("lat t busy", 32'(busy), 0);
    tick();
    m = '0; m[47] = 1'b1;
    chk("lat t+1 busy", 32'(busy), 1);
    chk("lat t+1 out_valid", 32'(out_valid), 0);
    chk("lat t+1 pe_ready_mask", 32'(pe_ready == m), 1);
    tick();
    chk("lat t+2 out_valid", 32'(out_valid), 1);
    chk("lat t+2 out_data", out_data, 32'hDEADBEEF);
    chk("lat t+2 pe_ready", 32'(|pe_ready), 0);
    pe_data[47*VL +: VL] = 32'h0;
    tick();
    chk("lat hold out_valid", 32'(out_valid), 1);
    chk("lat hold out_data", out_data, 32'hDEADBEEF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("lat released", 32'(out_valid), 0);

    for (int i = 0; i < 6; i++) run_req($sformatf("vec%0d", i), tbl[i]);

    // Back-pressure: one request parks in RESP, four fill the FIFO.
    pe_enable = '1;
    for (int k = 0; k < N; k++) pe_data[k*VL +: VL] = 32'(k);
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_row = 4'd1; req_col = IL'(c);
      chk($sformatf("fifo ready before push%0d", c), 32'(req_ready), 1);
      tick();
    end
    chk("fifo full req_ready", 32'(req_ready), 0);
    req_col = 5'd5;
    tick();
    req_valid = 1'b0;
    chk("fifo still full", 32'(req_ready), 0);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 200 && got < 5; c++) begin
      if (out_valid) begin
        chk($sformatf("fifo resp%0d col", got), 32'(out_col), 32'(got));
        chk($sformatf("fifo resp%0d data", got), out_data, 32'(14 + got));
        got++;
      end
      tick();
    end
    chk("fifo resp count", 32'(got), 5);
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) extra++;
      tick();
    end
    chk("fifo no extra resp", 32'(extra), 0);
    out_ready = 1'b0;
    pe_enable = '0;

    // Row 2 aliased to row tag 1: PEs 20 and 34 both match (1,6).
    scan_rows(1'b1);
    run_req("dual", '{1, 6, 20, 32'h11, 34, 32'h22, 32'h11, 1'b0, 1, 1});

    // Reset mid-WAIT with a second request queued.
    pe_enable = '0;
    req_valid = 1'b1; req_row = 4'd3; req_col = 5'd5;
    tick(); tick();
    req_valid = 1'b0;
    chk("rstwait busy before", 32'(busy), 1);
    chk("rstwait pe_ready before", 32'(|pe_ready), 1);
    #2 rst = 1'b0;
    #1;
    chk("rstwait pe_ready", 32'(|pe_ready), 0);
    chk("rstwait busy", 32'(busy), 0);
    chk("rstwait req_ready", 32'(req_ready), 1);
    chk("rstwait out_valid", 32'(out_valid), 0);
    tick();
    rst = 1'b1;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid || busy) extra++;
      tick();
    end
    chk("rstwait no activity", 32'(extra), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
